// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter that shares one memory port between instruction fetch (IF) and the MA stage.
// MA wins contention unless IF has been passed over STARVE_MAX times in a row; stuck transactions time out.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_valid,
  output logic              ma_stall,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_MA = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                if_elig;
  logic                ma_elig;
  logic                grant_if;
  logic                grant_ma;
  logic                done;
  logic                abort;

  // A requester is not eligible during its own valid cycle, so a held req is not re-issued.
  always_comb begin
    if_elig   = if_req & ~if_valid;
    ma_elig   = ma_req & ~ma_valid;
    grant_if  = 1'b0;
    grant_ma  = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        grant_ma = ma_elig & (~if_elig | (starve_cnt != STARVE_TOP));
        grant_if = if_elig & ~grant_ma;
        if (grant_ma) begin
          state_nxt = BUSY_MA;
        end else if (grant_if) begin
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MA: begin
        done  = mem_ready;
        abort = ~mem_ready & (wait_cnt == WAIT_LAST);
        if (done | abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      ma_rdata   <= '0;
      if_valid   <= 1'b0;
      ma_valid   <= 1'b0;
      mem_err    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      mem_en   <= grant_if | grant_ma;
      if_valid <= 1'b0;
      ma_valid <= 1'b0;
      mem_err  <= 1'b0;

      if (grant_ma) begin
        mem_rw    <= ma_we;
        mem_addr  <= ma_addr;
        mem_wdata <= ma_wdata;
        wait_cnt  <= '0;
        if (if_elig && (starve_cnt != STARVE_TOP)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end

      if (grant_if) begin
        mem_rw     <= 1'b0;
        mem_addr   <= if_addr;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end

      // A timeout completes like a normal access but leaves the read data untouched.
      if (done | abort) begin
        mem_err <= abort;
        if (state == BUSY_IF) begin
          if_valid <= 1'b1;
        end else begin
          ma_valid <= 1'b1;
        end
      end

      if (done && (state == BUSY_IF)) begin
        if_rdata <= mem_rdata;
      end

      if (done && (state == BUSY_MA) && !mem_rw) begin
        ma_rdata <= mem_rdata;
      end

      if ((state != IDLE) && !done && !abort) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    if_stall = if_req & ~if_valid;
    ma_stall = ma_req & ~ma_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset/vector table, directed multi-cycle corners,
// then random traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic              clk;
  logic              reset_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_wdata;
  logic [DATA_W-1:0] ma_rdata;
  logic              ma_valid;
  logic              ma_stall;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .ma_req   (ma_req),
    .ma_we    (ma_we),
    .ma_addr  (ma_addr),
    .ma_wdata (ma_wdata),
    .ma_rdata (ma_rdata),
    .ma_valid (ma_valid),
    .ma_stall (ma_stall),
    .mem_en   (mem_en),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_err  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the port and how long it has waited.
  int          m_owner;   // 0 none, 1 fetch, 2 MA
  int          m_waited;
  int          m_starve;
  logic        m_ie, m_me;
  logic        m_en, m_rw, m_if_valid, m_ma_valid, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_ma_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = 0; m_waited = 0; m_starve = 0;
      m_en = 0; m_rw = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_ma_rdata = '0;
      m_if_valid = 0; m_ma_valid = 0; m_err = 0;
    end else begin
      m_ie = if_req && !m_if_valid;
      m_me = ma_req && !m_ma_valid;
      m_if_valid = 0; m_ma_valid = 0; m_err = 0; m_en = 0;
      if (m_owner == 0) begin
        if (m_me && (!m_ie || m_starve < STARVE_MAX)) begin
          if (m_ie) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
          m_owner = 2; m_rw = ma_we; m_addr = ma_addr; m_wdata = ma_wdata;
          m_en = 1; m_waited = 0;
        end else if (m_ie) begin
          m_owner = 1; m_starve = 0; m_rw = 0; m_addr = if_addr;
          m_en = 1; m_waited = 0;
        end
      end else if (mem_ready) begin
        if (m_owner == 1) begin
          m_if_valid = 1; m_if_rdata = mem_rdata;
        end else begin
          m_ma_valid = 1;
          if (!m_rw) m_ma_rdata = mem_rdata;
        end
        m_owner = 0;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_err = 1;
          if (m_owner == 1) m_if_valid = 1; else m_ma_valid = 1;
          m_owner = 0;
        end
      end
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ma_req;
    logic        ma_we;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdata;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_en;
    logic        e_rw;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ifv;
    logic [31:0] e_ifr;
    logic        e_mav;
    logic [31:0] e_mar;
    logic        e_err;
    logic        e_ifs;
    logic        e_mas;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    int got[$];
    int exp_order[6];
    logic prev_ifv, prev_mav;
    int who;

    total = 0; bad = 0;
    // load, idle, store with waits, fetch, ignored ready in idle
    tbl[0] = '{0, 32'h0,   1, 0, 32'h40, 32'h0,        0, 32'h0,        1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 1};
    tbl[1] = '{0, 32'h0,   1, 0, 32'h40, 32'h0,        1, 32'h12345678, 0, 0, 32'h40,  32'h0,        0, 32'h0,        1, 32'h12345678, 0, 0, 0};
    tbl[2] = '{0, 32'h0,   0, 0, 32'h40, 32'h0,        0, 32'h0,        0, 0, 32'h40,  32'h0,        0, 32'h0,        0, 32'h12345678, 0, 0, 0};
    tbl[3] = '{0, 32'h0,   1, 1, 32'h80, 32'hA5A5A5A5, 0, 32'h0,        1, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        0, 32'h12345678, 0, 0, 1};
    tbl[4] = '{0, 32'h0,   1, 1, 32'h80, 32'hA5A5A5A5, 0, 32'h0,        0, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        0, 32'h12345678, 0, 0, 1};
    tbl[5] = '{0, 32'h0,   1, 1, 32'h80, 32'hA5A5A5A5, 0, 32'h0,        0, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        0, 32'h12345678, 0, 0, 1};
    tbl[6] = '{0, 32'h0,   1, 1, 32'h80, 32'hA5A5A5A5, 1, 32'hDEADBEEF, 0, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        1, 32'h12345678, 0, 0, 0};
    tbl[7] = '{1, 32'h100, 0, 1, 32'h80, 32'hA5A5A5A5, 1, 32'h0,        1, 0, 32'h100, 32'hA5A5A5A5, 0, 32'h0,        0, 32'h12345678, 0, 1, 0};
    tbl[8] = '{1, 32'h100, 0, 1, 32'h80, 32'hA5A5A5A5, 1, 32'hCAFEF00D, 0, 0, 32'h100, 32'hA5A5A5A5, 1, 32'hCAFEF00D, 0, 32'h12345678, 0, 0, 0};
    tbl[9] = '{0, 32'h100, 0, 1, 32'h80, 32'hA5A5A5A5, 1, 32'hFFFFFFFF, 0, 0, 32'h100, 32'hA5A5A5A5, 0, 32'hCAFEF00D, 0, 32'h12345678, 0, 0, 0};

    reset_n = 0; if_req = 0; if_addr = '0; ma_req = 0; ma_we = 0;
    ma_addr = '0; ma_wdata = '0; mem_ready = 0; mem_rdata = '0;
    #2;
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_rw", mem_rw, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0); chk("rst_ma_rdata", ma_rdata, 0);
    chk("rst_if_valid", if_valid, 0); chk("rst_ma_valid", ma_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    #10 reset_n = 1;

    for (int i = 0; i < 10; i++) begin
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      ma_req = tbl[i].ma_req; ma_we = tbl[i].ma_we;
      ma_addr = tbl[i].ma_addr; ma_wdata = tbl[i].ma_wdata;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d_mem_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("v%0d_mem_rw", i), mem_rw, tbl[i].e_rw);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_if_valid", i), if_valid, tbl[i].e_ifv);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_ifr);
      chk($sformatf("v%0d_ma_valid", i), ma_valid, tbl[i].e_mav);
      chk($sformatf("v%0d_ma_rdata", i), ma_rdata, tbl[i].e_mar);
      chk($sformatf("v%0d_mem_err", i), mem_err, tbl[i].e_err);
      chk($sformatf("v%0d_if_stall", i), if_stall, tbl[i].e_ifs);
      chk($sformatf("v%0d_ma_stall", i), ma_stall, tbl[i].e_mas);
    end

    // Timeout on a fetch with memory never ready
    if_req = 1; if_addr = 32'h200; mem_ready = 0;
    @(posedge clk); #1;
    chk("to_grant", mem_en, 1);
    n = 0; seen = 0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(posedge clk); #1;
      if (if_valid) begin seen = 1; n = k; end
    end
    chk("to_edges", n, TIMEOUT);
    chk("to_err", mem_err, 1);
    chk("to_rdata_kept", if_rdata, 32'hCAFEF00D);
    chk("to_addr_held", mem_addr, 32'h200);
    if_req = 0;
    @(posedge clk); #1;
    chk("to_valid_pulse", if_valid, 0);
    chk("to_err_pulse", mem_err, 0);
    chk("to_idle_no_en", mem_en, 0);

    // Continuous contention with zero-wait memory
    exp_order = '{2, 1, 2, 1, 2, 1};
    if_addr = 32'h300; ma_addr = 32'h400; ma_we = 0;
    if_req = 1; ma_req = 1; mem_ready = 1; mem_rdata = 32'h55;
    prev_ifv = if_valid; prev_mav = ma_valid;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        who = (mem_addr == 32'h400) ? 2 : 1;
        got.push_back(who);
        chk("own_valid_grant", (who == 2) ? prev_mav : prev_ifv, 0);
      end
      prev_ifv = if_valid; prev_mav = ma_valid;
    end
    chk("cont_grants", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++) chk($sformatf("cont_order%0d", k), got[k], exp_order[k]);
    if_req = 0; ma_req = 0; mem_ready = 0;
    @(posedge clk); #1;

    // Reset in the middle of an MA load
    ma_req = 1; ma_we = 0; ma_addr = 32'h40; ma_wdata = 32'h77; mem_rdata = 32'h9ABCDEF0;
    @(posedge clk); #1;
    chk("rmid_grant", mem_en, 1);
    @(posedge clk); @(posedge clk); #3;
    mem_ready = 1; reset_n = 0;
    #1;
    chk("rmid_en", mem_en, 0);       chk("rmid_rw", mem_rw, 0);
    chk("rmid_addr", mem_addr, 0);   chk("rmid_wdata", mem_wdata, 0);
    chk("rmid_ifr", if_rdata, 0);    chk("rmid_mar", ma_rdata, 0);
    chk("rmid_ifv", if_valid, 0);    chk("rmid_mav", ma_valid, 0);
    chk("rmid_err", mem_err, 0);
    @(posedge clk); #1;
    chk("rmid_no_valid", ma_valid, 0);
    #2 reset_n = 1;
    @(posedge clk); #1;
    chk("rmid_regrant", mem_en, 1);
    chk("rmid_regrant_addr", mem_addr, 32'h40);
    chk("rmid_regrant_nov", ma_valid, 0);
    @(posedge clk); #1;
    chk("rmid_done", ma_valid, 1);
    chk("rmid_rdata", ma_rdata, 32'h9ABCDEF0);
    ma_req = 0; mem_ready = 0;
    @(posedge clk); #1;

    // Stall held while a store waits five cycles
    ma_req = 1; ma_we = 1; ma_addr = 32'h500; ma_wdata = 32'h11;
    #1;
    chk("stall_pre", ma_stall, 1);
    @(posedge clk); #1;
    chk("stall_grant", mem_en, 1);
    n = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (ma_valid) begin seen = 1; n = k; end
      else chk("stall_hold", ma_stall, 1);
      if (k == 4) mem_ready = 1;
    end
    chk("stall_latency", n, 5);
    chk("stall_release", ma_stall, 0);
    chk("stall_store_rdata", ma_rdata, 32'h9ABCDEF0);
    ma_req = 0; mem_ready = 0;
    @(posedge clk); #1;
    chk("stall_idle", ma_stall, 0);

    // Random traffic against the model
    #2 reset_n = 0;
    if_req = 0; ma_req = 0;
    #2 reset_n = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      chk("r_mem_en", mem_en, m_en);
      chk("r_mem_rw", mem_rw, m_rw);
      chk("r_mem_addr", mem_addr, m_addr);
      chk("r_mem_wdata", mem_wdata, m_wdata);
      chk("r_if_valid", if_valid, m_if_valid);
      chk("r_if_rdata", if_rdata, m_if_rdata);
      chk("r_ma_valid", ma_valid, m_ma_valid);
      chk("r_ma_rdata", ma_rdata, m_ma_rdata);
      chk("r_mem_err", mem_err, m_err);
      chk("r_if_stall", if_stall, if_req & ~m_if_valid);
      chk("r_ma_stall", ma_stall, ma_req & ~m_ma_valid);
      if (!if_req) begin
        if ($urandom_range(0, 1) == 1) begin if_req = 1; if_addr = $urandom; end
      end else if (m_if_valid) begin
        if ($urandom_range(0, 1) == 1) if_req = 0;
        if_addr = $urandom;
      end
      if (!ma_req) begin
        if ($urandom_range(0, 1) == 1) begin
          ma_req = 1; ma_we = 1'($urandom_range(0, 1)); ma_addr = $urandom; ma_wdata = $urandom;
        end
      end else if (m_ma_valid) begin
        if ($urandom_range(0, 1) == 1) ma_req = 0;
        ma_we = 1'($urandom_range(0, 1)); ma_addr = $urandom; ma_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
